// File: rtl/mouse_dir_tracker_if.sv
// Bundles the sample strobe, cursor coordinates, buttons and direction outputs
// of the mouse direction tracker.
interface mouse_dir_tracker_if #(
  parameter int CW   = 11,
  parameter int CNTW = 16
) ();
  logic            sample;
  logic [CW-1:0]   x;
  logic [CW-1:0]   y;
  logic            btn_l;
  logic            btn_r;
  logic [8:0]      dir;
  logic            moving;
  logic            drag;
  logic            click_l;
  logic            click_r;
  logic [CNTW-1:0] step_cnt;

  modport master (
    output sample, x, y, btn_l, btn_r,
    input  dir, moving, drag, click_l, click_r, step_cnt
  );

  modport slave (
    input  sample, x, y, btn_l, btn_r,
    output dir, moving, drag, click_l, click_r, step_cnt
  );
endinterface

// File: rtl/mouse_dir_tracker.sv
// Classifies cursor motion into a 3x3 one-hot direction with deadzone, hold
// timeout back to centre, drag detection, click pulses and a step counter.
module mouse_dir_tracker #(
  parameter int CW       = 11,
  parameter int DEADZONE = 2,
  parameter int HOLD     = 3,
  parameter int CNTW     = 16
) (
  input  logic PS2_CLK,
  input  logic reset,
  mouse_dir_tracker_if.slave mif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [8:0]      DIR_CENTRE = 9'b000010000;
  localparam logic signed [CW:0] DZ_POS  = (CW+1)'(DEADZONE);
  localparam logic signed [CW:0] DZ_NEG  = -DZ_POS;
  localparam logic [7:0]      HOLD_LIM   = 8'(HOLD);
  localparam logic [CNTW-1:0] STEP_MAX   = {CNTW{1'b1}};

  // Map a signed axis delta onto 0 (negative), 1 (still) or 2 (positive).
  function automatic logic [1:0] classify(input logic signed [CW:0] d);
    if (d < DZ_NEG) begin
      return 2'd0;
    end else if (d > DZ_POS) begin
      return 2'd2;
    end else begin
      return 2'd1;
    end
  endfunction

  function automatic logic [8:0] dir_onehot(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    idx = 4'({2'b00, row}) * 4'd3 + 4'({2'b00, col});
    case (idx)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8: return 9'b000000001 << idx;
      default:                return DIR_CENTRE;
    endcase
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [7:0]      hold_cnt_r;
  logic [7:0]      hold_nxt_s;
  logic [7:0]      hold_inc_s;
  logic            prime_r;
  logic [CW-1:0]   prev_x_r;
  logic [CW-1:0]   prev_y_r;
  logic [8:0]      dir_r;
  logic            moving_r;
  logic            drag_r;
  logic            btn_l_q_r;
  logic            btn_r_q_r;
  logic            click_l_r;
  logic            click_r_r;
  logic [CNTW-1:0] step_cnt_r;

  logic signed [CW:0] dx_s;
  logic signed [CW:0] dy_s;
  logic [1:0]         col_s;
  logic [1:0]         row_s;
  logic               motion_s;
  logic               still_s;

  // Raw signed differences; wrap-around deliberately stays uncorrected.
  assign dx_s  = $signed({1'b0, mif.x}) - $signed({1'b0, prev_x_r});
  assign dy_s  = $signed({1'b0, mif.y}) - $signed({1'b0, prev_y_r});
  assign col_s = classify(dx_s);
  assign row_s = classify(dy_s);

  // The priming sample is neither motion nor motion-free.
  assign motion_s   = mif.sample && prime_r && ((row_s != 2'd1) || (col_s != 2'd1));
  assign still_s    = mif.sample && prime_r && !motion_s;
  assign hold_inc_s = hold_cnt_r + 8'd1;

  // Next-state logic; the sample that enters HOLD counts as the first motion-free one.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (motion_s) begin
          state_nxt_s = S_MOVE;
        end else begin
          state_nxt_s = S_IDLE;
        end
        hold_nxt_s = 8'd0;
      end
      S_MOVE: begin
        if (still_s) begin
          state_nxt_s = S_HOLD;
          hold_nxt_s  = 8'd1;
        end else begin
          state_nxt_s = S_MOVE;
          hold_nxt_s  = 8'd0;
        end
      end
      S_HOLD: begin
        if (motion_s) begin
          state_nxt_s = S_MOVE;
          hold_nxt_s  = 8'd0;
        end else if (still_s) begin
          if (hold_inc_s >= HOLD_LIM) begin
            state_nxt_s = S_IDLE;
            hold_nxt_s  = 8'd0;
          end else begin
            state_nxt_s = S_HOLD;
            hold_nxt_s  = hold_inc_s;
          end
        end else begin
          state_nxt_s = S_HOLD;
          hold_nxt_s  = hold_cnt_r;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        hold_nxt_s  = 8'd0;
      end
    endcase
  end

  // FSM, hold counter and previous-coordinate registers.
  always_ff @(posedge PS2_CLK) begin
    if (reset) begin
      state_r    <= S_IDLE;
      hold_cnt_r <= 8'd0;
      prime_r    <= 1'b0;
      prev_x_r   <= '0;
      prev_y_r   <= '0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      if (mif.sample) begin
        prev_x_r <= mif.x;
        prev_y_r <= mif.y;
        prime_r  <= 1'b1;
      end
    end
  end

  // Direction, status and step counter outputs.
  always_ff @(posedge PS2_CLK) begin
    if (reset) begin
      dir_r      <= DIR_CENTRE;
      moving_r   <= 1'b0;
      drag_r     <= 1'b0;
      step_cnt_r <= '0;
    end else begin
      moving_r <= (state_nxt_s == S_MOVE);
      drag_r   <= (state_nxt_s == S_MOVE) && mif.btn_l;
      if (motion_s) begin
        dir_r <= dir_onehot(row_s, col_s);
        if (step_cnt_r != STEP_MAX) begin
          step_cnt_r <= step_cnt_r + CNTW'(1);
        end
      end else if (state_nxt_s == S_IDLE) begin
        dir_r <= DIR_CENTRE;
      end
    end
  end

  // Button rising-edge detection, independent of the sample strobe.
  always_ff @(posedge PS2_CLK) begin
    if (reset) begin
      btn_l_q_r <= 1'b0;
      btn_r_q_r <= 1'b0;
      click_l_r <= 1'b0;
      click_r_r <= 1'b0;
    end else begin
      btn_l_q_r <= mif.btn_l;
      btn_r_q_r <= mif.btn_r;
      click_l_r <= mif.btn_l && !btn_l_q_r;
      click_r_r <= mif.btn_r && !btn_r_q_r;
    end
  end

  assign mif.dir      = dir_r;
  assign mif.moving   = moving_r;
  assign mif.drag     = drag_r;
  assign mif.click_l  = click_l_r;
  assign mif.click_r  = click_r_r;
  assign mif.step_cnt = step_cnt_r;

endmodule

// File: tb/tb_mouse_dir_tracker.sv
// Directed bench for mouse_dir_tracker; a second instance with a narrow step
// counter exercises saturation on the same stimulus.
module tb_mouse_dir_tracker;

  logic PS2_CLK;
  logic reset;
  int   n_checks;
  int   n_fail;

  mouse_dir_tracker_if #(.CW(11), .CNTW(16)) mif ();
  mouse_dir_tracker_if #(.CW(11), .CNTW(4))  sif ();

  mouse_dir_tracker #(.CW(11), .DEADZONE(2), .HOLD(3), .CNTW(16)) u_dut (
    .PS2_CLK (PS2_CLK),
    .reset   (reset),
    .mif     (mif)
  );

  mouse_dir_tracker #(.CW(11), .DEADZONE(2), .HOLD(3), .CNTW(4)) u_sat (
    .PS2_CLK (PS2_CLK),
    .reset   (reset),
    .mif     (sif)
  );

  assign sif.sample = mif.sample;
  assign sif.x      = mif.x;
  assign sif.y      = mif.y;
  assign sif.btn_l  = mif.btn_l;
  assign sif.btn_r  = mif.btn_r;

  initial PS2_CLK = 1'b0;
  always #5 PS2_CLK = ~PS2_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one coordinate pair for one cycle; returns half a cycle after it is taken.
  task automatic samp(input int xv, input int yv);
    @(negedge PS2_CLK);
    mif.sample = 1'b1;
    mif.x      = 11'(xv);
    mif.y      = 11'(yv);
    @(negedge PS2_CLK);
    mif.sample = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PS2_CLK);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    mif.sample = 1'b0;
    mif.x      = 11'd0;
    mif.y      = 11'd0;
    mif.btn_l  = 1'b0;
    mif.btn_r  = 1'b0;
    idle(3);
    reset = 1'b0;

    check("rst_dir", 32'(mif.dir), 32'h010);
    check("rst_moving", 32'(mif.moving), 32'd0);
    check("rst_step", 32'(mif.step_cnt), 32'd0);
    check("rst_clicks", 32'({mif.click_l, mif.click_r, mif.drag}), 32'd0);

    samp(100, 100);
    samp(100, 100);
    check("same_dir", 32'(mif.dir), 32'h010);
    check("same_moving", 32'(mif.moving), 32'd0);
    check("same_step", 32'(mif.step_cnt), 32'd0);

    samp(110, 100);
    check("right_dir", 32'(mif.dir), 32'h020);
    check("right_moving", 32'(mif.moving), 32'd1);
    check("right_step", 32'(mif.step_cnt), 32'd1);

    samp(111, 100);
    check("hold1_dir", 32'(mif.dir), 32'h020);
    check("hold1_moving", 32'(mif.moving), 32'd0);
    samp(111, 100);
    check("hold2_dir", 32'(mif.dir), 32'h020);

    samp(90, 80);
    check("upleft_dir", 32'(mif.dir), 32'h001);
    check("upleft_moving", 32'(mif.moving), 32'd1);
    check("upleft_step", 32'(mif.step_cnt), 32'd2);

    samp(100, 100);
    check("downright_dir", 32'(mif.dir), 32'h100);
    check("downright_step", 32'(mif.step_cnt), 32'd3);

    idle(3);
    check("nosample_dir", 32'(mif.dir), 32'h100);
    check("nosample_moving", 32'(mif.moving), 32'd1);
    check("nosample_step", 32'(mif.step_cnt), 32'd3);

    samp(102, 98);
    check("dz_dir", 32'(mif.dir), 32'h100);
    check("dz_moving", 32'(mif.moving), 32'd0);
    check("dz_step", 32'(mif.step_cnt), 32'd3);
    samp(102, 98);
    check("hold_b2_dir", 32'(mif.dir), 32'h100);
    samp(102, 98);
    check("timeout_dir", 32'(mif.dir), 32'h010);
    check("timeout_moving", 32'(mif.moving), 32'd0);
    samp(102, 98);
    check("idle_dir", 32'(mif.dir), 32'h010);

    samp(130, 100);
    check("move2_dir", 32'(mif.dir), 32'h020);
    check("move2_step", 32'(mif.step_cnt), 32'd4);
    @(negedge PS2_CLK);
    mif.btn_l = 1'b1;
    mif.btn_r = 1'b1;
    @(negedge PS2_CLK);
    check("click_l_pulse", 32'(mif.click_l), 32'd1);
    check("click_r_pulse", 32'(mif.click_r), 32'd1);
    check("drag_on", 32'(mif.drag), 32'd1);
    mif.btn_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PS2_CLK);
      check("click_l_low", 32'(mif.click_l), 32'd0);
      check("click_r_low", 32'(mif.click_r), 32'd0);
      check("drag_held", 32'(mif.drag), 32'd1);
    end
    samp(130, 100);
    check("drag_exit", 32'(mif.drag), 32'd0);
    check("drag_exit_moving", 32'(mif.moving), 32'd0);
    mif.btn_l = 1'b0;

    samp(0, 100);
    check("left_dir", 32'(mif.dir), 32'h008);
    samp(2047, 100);
    check("wrap_dir", 32'(mif.dir), 32'h020);
    check("wrap_step", 32'(mif.step_cnt), 32'd6);
    check("sat_pre", 32'(sif.step_cnt), 32'd6);

    for (int i = 0; i < 16; i++) begin
      samp((i % 2 == 0) ? 0 : 100, 100);
    end
    check("loop_step", 32'(mif.step_cnt), 32'd22);
    check("sat_step", 32'(sif.step_cnt), 32'd15);

    samp(100, 100);
    check("pre_rst_hold", 32'(mif.moving), 32'd0);
    @(negedge PS2_CLK);
    reset      = 1'b1;
    mif.sample = 1'b1;
    mif.x      = 11'd300;
    mif.y      = 11'd300;
    mif.btn_l  = 1'b1;
    @(negedge PS2_CLK);
    reset      = 1'b0;
    mif.sample = 1'b0;
    mif.btn_l  = 1'b0;
    check("rst2_dir", 32'(mif.dir), 32'h010);
    check("rst2_moving", 32'(mif.moving), 32'd0);
    check("rst2_step", 32'(mif.step_cnt), 32'd0);
    check("rst2_sat_step", 32'(sif.step_cnt), 32'd0);
    check("rst2_outs", 32'({mif.click_l, mif.click_r, mif.drag}), 32'd0);

    samp(500, 500);
    check("prime2_moving", 32'(mif.moving), 32'd0);
    check("prime2_step", 32'(mif.step_cnt), 32'd0);
    samp(500, 500);
    check("prime2_still", 32'(mif.moving), 32'd0);
    samp(510, 500);
    check("post_rst_dir", 32'(mif.dir), 32'h020);
    check("post_rst_step", 32'(mif.step_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
